// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory block server: FSM state
// encoding, block/byte geometry and the default read latency.
package imem_pkg;

  typedef enum logic {
    IMEM_IDLE = 1'b0,
    IMEM_BUSY = 1'b1
  } imem_state_t;

  localparam int BLOCK_BYTES         = 16;
  localparam int BLOCK_BITS          = 128;
  localparam int ADDR_BITS           = 10;
  localparam int OFFSET_BITS         = 4;
  localparam int CNT_BITS            = 4;
  localparam int DEFAULT_READ_CYCLES = 5;

endpackage

// File: rtl/imem_latency_counter.sv
// Down-counter used to time a memory access: loadable, decrements while
// enabled, saturates at zero and flags when it has reached zero.
module imem_latency_counter
  import imem_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [CNT_BITS-1:0] load_value,
  input  logic                dec,
  output logic [CNT_BITS-1:0] count,
  output logic                zero
);

  // Load takes priority over decrement; the count never wraps below zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/imem_block_server.sv
// Instruction memory behind the instruction cache. Serves one 16-byte block
// per mem_read request after a fixed latency, with a byte-wide preload port.
// Optional macro IMEM_NEXT_BLOCK_PREFETCH_EN adds a one-block next-line
// prefetch buffer that shortens sequential fetches.
module imem_block_server
  import imem_pkg::*;
#(
  parameter int READ_CYCLES = DEFAULT_READ_CYCLES,
  parameter int NUM_BLOCKS  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic [5:0]            mem_address,
  output logic [BLOCK_BITS-1:0] mem_inst,
  output logic                  mem_busywait,
  input  logic                  load_en,
  input  logic [ADDR_BITS-1:0]  load_addr,
  input  logic [7:0]            load_byte
);

  localparam int BLK_W = $clog2(NUM_BLOCKS);
  localparam int MEM_W = BLK_W + OFFSET_BITS;
  localparam int DEPTH = NUM_BLOCKS * BLOCK_BYTES;
  localparam logic [CNT_BITS-1:0] RC_LOAD = CNT_BITS'(READ_CYCLES - 1);

  imem_state_t           state;
  imem_state_t           state_next;
  logic [BLK_W-1:0]      req_addr;
  logic [BLK_W-1:0]      req_in;
  logic [7:0]            mem [DEPTH];
  logic [BLOCK_BITS-1:0] rd_block;
  logic [BLOCK_BITS-1:0] ret_block;
  logic [CNT_BITS-1:0]   start_count;
  logic [CNT_BITS-1:0]   main_count_unused;
  logic                  cnt_zero;
  logic                  cnt_dec;
  logic                  accept;
  logic                  complete;

  assign req_in = mem_address[BLK_W-1:0];

  imem_latency_counter u_main_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (start_count),
    .dec        (cnt_dec),
    .count      (main_count_unused),
    .zero       (cnt_zero)
  );

  // Preload writes land in any state; the array is never cleared by reset.
  always_ff @(posedge clock) begin
    if (load_en) begin
      mem[load_addr[MEM_W-1:0]] <= load_byte;
    end
  end

  // Gather the latched block little-endian; sampled on the completion edge.
  always_comb begin
    rd_block = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      rd_block[8*k +: 8] = mem[{req_addr, OFFSET_BITS'(k)}];
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IMEM_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Accept a request in IDLE; in BUSY count down and complete at zero.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IMEM_IDLE: begin
        if (mem_read) begin
          accept     = 1'b1;
          state_next = IMEM_BUSY;
        end
      end
      IMEM_BUSY: begin
        if (cnt_zero) begin
          complete   = 1'b1;
          state_next = IMEM_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_next = IMEM_IDLE;
    endcase
  end

  // Registered handshake outputs and the latched request address.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_busywait <= 1'b0;
      mem_inst     <= '0;
      req_addr     <= '0;
    end else begin
      if (accept) begin
        req_addr     <= req_in;
        mem_busywait <= 1'b1;
      end
      if (complete) begin
        mem_busywait <= 1'b0;
        mem_inst     <= ret_block;
      end
    end
  end

`ifdef IMEM_NEXT_BLOCK_PREFETCH_EN
  logic                  pf_valid;
  logic                  pf_active;
  logic                  use_buf;
  logic [BLK_W-1:0]      pf_addr;
  logic [BLOCK_BITS-1:0] pf_buf;
  logic [BLOCK_BITS-1:0] pf_block;
  logic [CNT_BITS-1:0]   pf_count;
  logic                  pf_zero;
  logic                  req_match;
  logic                  load_hits_pf;
  logic                  hit;
  logic                  follow;

  assign req_match    = (req_in == pf_addr);
  assign load_hits_pf = load_en && (load_addr[MEM_W-1:OFFSET_BITS] == pf_addr);
  assign hit          = pf_valid && req_match && !load_hits_pf;
  assign follow       = pf_active && req_match;
  assign ret_block    = use_buf ? pf_buf : rd_block;

  // A hit returns the buffer after one cycle; a request for the block still
  // being fetched completes on the same edge the prefetch would have.
  always_comb begin
    start_count = RC_LOAD;
    if (hit) begin
      start_count = '0;
    end else if (follow) begin
      start_count = (pf_count == '0) ? '0 : pf_count - 1'b1;
    end
  end

  imem_latency_counter u_pf_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (complete),
    .load_value (RC_LOAD),
    .dec        (pf_active),
    .count      (pf_count),
    .zero       (pf_zero)
  );

  // Gather the block being prefetched.
  always_comb begin
    pf_block = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      pf_block[8*k +: 8] = mem[{pf_addr, OFFSET_BITS'(k)}];
    end
  end

  // Prefetch bookkeeping; later statements override earlier ones, so a new
  // prefetch started by a completion wins over aborts and invalidations.
  always_ff @(posedge clock) begin
    if (reset) begin
      pf_valid  <= 1'b0;
      pf_active <= 1'b0;
      pf_addr   <= '0;
      pf_buf    <= '0;
      use_buf   <= 1'b0;
    end else begin
      if (accept) begin
        use_buf <= hit;
      end
      if (pf_active && pf_zero) begin
        pf_buf    <= pf_block;
        pf_valid  <= 1'b1;
        pf_active <= 1'b0;
      end
      if (load_hits_pf) begin
        pf_valid  <= 1'b0;
        pf_active <= 1'b0;
      end
      if (accept && !hit && !follow) begin
        pf_active <= 1'b0;
      end
      if (complete) begin
        pf_addr   <= req_addr + 1'b1;
        pf_active <= 1'b1;
        pf_valid  <= 1'b0;
      end
    end
  end
`else
  assign start_count = RC_LOAD;
  assign ret_block   = rd_block;
`endif

endmodule

// File: tb/tb_imem_block_server.sv
// Self-checking bench for imem_block_server: directed scenarios plus a
// randomized read/preload mix checked against a byte-array reference model.
module tb_imem_block_server;

  localparam int RC = 5;
`ifdef IMEM_NEXT_BLOCK_PREFETCH_EN
  localparam int L2 = RC - 1;
`else
  localparam int L2 = RC;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_inst;
  logic         mem_busywait;
  logic         load_en;
  logic [9:0]   load_addr;
  logic [7:0]   load_byte;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [7:0] ref_mem [1024];

  imem_block_server #(.READ_CYCLES(RC), .NUM_BLOCKS(64)) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_inst     (mem_inst),
    .mem_busywait (mem_busywait),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_byte    (load_byte)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] ref_block(input int b);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_mem[b*16 + k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic write_byte(input int a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = 10'(a);
    load_byte = d;
    tick();
    load_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issue one read from IDLE and count the cycles mem_busywait stays high.
  task automatic applyStimulus(input int blk, output int busy,
                               output logic [127:0] data);
    mem_read    = 1'b1;
    mem_address = 6'(blk);
    tick();
    mem_read = 1'b0;
    busy = 0;
    while (mem_busywait && busy < 40) begin
      busy++;
      tick();
    end
    data = mem_inst;
  endtask

  task automatic read_check(input string tag, input int blk, input int exp_lat);
    int busy;
    logic [127:0] data;
    applyStimulus(blk, busy, data);
    checkOutput({tag, "_data"}, data, ref_block(blk));
    checkOutput({tag, "_lat"}, 128'(busy), 128'(exp_lat));
  endtask

  initial begin
    int busy;
    int n;
    logic [127:0] data;
    logic [31:0] pat;
    logic [31:0] exp_pat;
    logic [7:0] old_byte;

    reset = 1'b1; mem_read = 1'b0; mem_address = '0;
    load_en = 1'b0; load_addr = '0; load_byte = '0;
    repeat (3) tick();
    checkOutput("reset_busywait", 128'(mem_busywait), 128'd0);
    checkOutput("reset_inst", mem_inst, 128'd0);
    reset = 1'b0;
    tick();

    for (int a = 0; a < 1024; a++) write_byte(a, 8'($urandom));
    for (int a = 0; a < 16; a++) write_byte(a, 8'(a));
    for (int a = 1008; a < 1024; a++) write_byte(a, 8'hA5);

    read_check("blk0", 0, RC);
    checkOutput("blk0_literal", mem_inst, 128'h0F0E0D0C0B0A09080706050403020100);
    read_check("blk63", 63, RC);
    checkOutput("blk63_literal", mem_inst, {16{8'hA5}});
    read_check("blk30", 30, RC);

    // Back-to-back: mem_read held high across the first completion.
    mem_read = 1'b1; mem_address = 6'd0; pat = '0; exp_pat = '0;
    n = RC + L2 + 2;
    for (int i = 0; i < n; i++) begin
      tick();
      pat[i] = mem_busywait;
      if (i == 0) mem_address = 6'd1;
      if (i == RC) checkOutput("b2b_first_data", mem_inst, ref_block(0));
      if (i == RC + 1) mem_read = 1'b0;
    end
    checkOutput("b2b_second_data", mem_inst, ref_block(1));
    for (int i = 0; i < n; i++) exp_pat[i] = (i < RC) || (i > RC && i <= RC + L2);
    checkOutput("b2b_busy_pattern", 128'(pat), 128'(exp_pat));

    // Reset during the third busy cycle aborts the read.
    mem_read = 1'b1; mem_address = 6'd0;
    tick();
    mem_read = 1'b0;
    tick(); tick();
    checkOutput("rst_mid_busy_before", 128'(mem_busywait), 128'd1);
    reset = 1'b1;
    tick();
    checkOutput("rst_mid_busywait", 128'(mem_busywait), 128'd0);
    checkOutput("rst_mid_inst", mem_inst, 128'd0);
    reset = 1'b0;
    tick();
    checkOutput("rst_hold_inst", mem_inst, 128'd0);
    read_check("rst_reread", 0, RC);

    // Address change and a preload into the in-flight block during BUSY.
    mem_read = 1'b1; mem_address = 6'd2;
    tick();
    busy = mem_busywait ? 1 : 0;
    mem_read = 1'b0; mem_address = 6'd5;
    load_en = 1'b1; load_addr = 10'd32; load_byte = 8'h77;
    tick();
    load_en = 1'b0;
    ref_mem[32] = 8'h77;
    while (mem_busywait && busy < 40) begin
      busy++;
      tick();
    end
    checkOutput("addr_change_data", mem_inst, ref_block(2));
    checkOutput("addr_change_byte0", 128'(mem_inst[7:0]), 128'h77);
    checkOutput("addr_change_lat", 128'(busy), 128'(RC));

    // A preload on the completion edge is not seen by that read.
    old_byte = ref_mem[160];
    mem_read = 1'b1; mem_address = 6'd10;
    tick();
    mem_read = 1'b0;
    busy = 0;
    for (int i = 0; i < RC; i++) begin
      if (mem_busywait) busy++;
      if (i == RC - 1) begin
        load_en = 1'b1; load_addr = 10'd160; load_byte = ~old_byte;
      end
      tick();
    end
    load_en = 1'b0;
    checkOutput("edge_wr_lat", 128'(busy), 128'(RC));
    checkOutput("edge_wr_done", 128'(mem_busywait), 128'd0);
    checkOutput("edge_wr_data", mem_inst, ref_block(10));
    ref_mem[160] = ~old_byte;
    read_check("edge_wr_reread", 10, RC);

    // Randomized preloads, idle gaps and reads.
    for (int it = 0; it < 24; it++) begin
      int nw;
      int gap;
      int blk;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) write_byte($urandom_range(0, 1023), 8'($urandom));
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      blk = $urandom_range(0, 63);
      applyStimulus(blk, busy, data);
      checkOutput($sformatf("rand%0d_data", it), data, ref_block(blk));
`ifdef IMEM_NEXT_BLOCK_PREFETCH_EN
      checkOutput($sformatf("rand%0d_lat_bound", it),
                  128'(busy >= 1 && busy <= RC), 128'd1);
`else
      checkOutput($sformatf("rand%0d_lat", it), 128'(busy), 128'(RC));
`endif
    end

`ifdef IMEM_NEXT_BLOCK_PREFETCH_EN
    // Prefetch scenarios starting from a clean buffer.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    read_check("pf_blk4", 4, RC);
    repeat (6) tick();
    read_check("pf_hit_blk5", 5, 1);
    read_check("pf_miss_blk9", 9, RC);
    read_check("pf_inflight_blk10", 10, RC - 1);
    repeat (6) tick();
    write_byte(11*16 + 3, ~ref_mem[11*16 + 3]);
    read_check("pf_invalidated_blk11", 11, RC);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
